// File: rtl/cascade_counter_pkg.sv
// cascade_counter_pkg -- shared definitions for the cascaded modulo counter.
//   calc_dw   : digit width for a given modulus, never less than one bit
//   dir_e     : count direction encoding (DIR_UP = 0, DIR_DOWN = 1)
//   *_MIN/MAX : legal ranges of NUM_DIGITS and MODULUS
package cascade_counter_pkg;

  localparam int unsigned NUM_DIGITS_MIN = 1;
  localparam int unsigned NUM_DIGITS_MAX = 16;
  localparam int unsigned MODULUS_MIN    = 2;
  localparam int unsigned MODULUS_MAX    = 256;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int unsigned calc_dw(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/mod_counter_digit.sv
// mod_counter_digit -- one modulo-MODULUS digit of the cascade.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   step            : advance this digit by one in direction dir
//   dir             : DIR_UP / DIR_DOWN
//   load, ld_val    : parallel load, clamped to MODULUS-1
//   clear           : synchronous clear to zero (beats load and step)
//   q               : registered digit value
//   at_max, at_zero : q == MODULUS-1 / q == 0, used for the carry chain
module mod_counter_digit
  import cascade_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned DW      = calc_dw(MODULUS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          dir,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  input  logic          clear,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_zero
);

  localparam logic [DW-1:0] MAXV = DW'(MODULUS - 1);

  logic [DW-1:0] q_next;

  assign at_max  = (q == MAXV);
  assign at_zero = (q == '0);

  always_comb begin
    q_next = q;
    if (clear) begin
      q_next = '0;
    end else if (load) begin
      q_next = (ld_val > MAXV) ? MAXV : ld_val;
    end else if (step) begin
      if (dir == DIR_DOWN) begin
        q_next = at_zero ? MAXV : (q - DW'(1));
      end else begin
        q_next = at_max ? '0 : (q + DW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/cascade_counter.sv
// cascade_counter -- NUM_DIGITS cascaded modulo-MODULUS digits.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   en       : count enable for digit 0
//   clear    : synchronous clear of q and wrapped
//   load     : parallel load of load_val (per-digit clamp to MODULUS-1)
//   load_val : load value, digit i at [i*DW +: DW]
//   dir      : 1 = down, 0 = up; only with CASCADE_COUNTER_UPDOWN_EN
//   q        : registered count, digit 0 least significant
//   tc       : terminal count (all max going up, all zero going down)
//   rco      : en & tc & ~clear & ~load, for chaining instances
//   wrapped  : sticky flag, set on full-range wrap, cleared by clear/rst
// Build option: define CASCADE_COUNTER_UPDOWN_EN for up/down counting;
// otherwise the counter is up-only and has no dir port.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS = 4,
  parameter  int unsigned MODULUS    = 10,
  localparam int unsigned DW         = calc_dw(MODULUS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   load,
  input  logic [NUM_DIGITS*DW-1:0] load_val,
`ifdef CASCADE_COUNTER_UPDOWN_EN
  input  logic                   dir,
`endif
  output logic [NUM_DIGITS*DW-1:0] q,
  output logic                   tc,
  output logic                   rco,
  output logic                   wrapped
);

  logic                  dir_i;
  logic [NUM_DIGITS-1:0] step;
  logic [NUM_DIGITS-1:0] at_max;
  // chain[i]: digit i is at the value from which it would carry/borrow
  logic [NUM_DIGITS-1:0] chain;

`ifdef CASCADE_COUNTER_UPDOWN_EN
  logic [NUM_DIGITS-1:0] at_zero;
  assign dir_i = dir;
  assign chain = (dir_i == DIR_DOWN) ? at_zero : at_max;
`else
  assign dir_i = DIR_UP;
  assign chain = at_max;
`endif

  assign tc  = &chain;
  assign rco = en & tc & ~clear & ~load;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign step[i] = en;
    end else begin : g_next
      assign step[i] = step[i-1] & chain[i-1];
    end

    mod_counter_digit #(
      .MODULUS (MODULUS),
      .DW      (DW)
    ) u_digit (
      .clk     (clk),
      .rst     (rst),
      .step    (step[i]),
      .dir     (dir_i),
      .load    (load),
      .ld_val  (load_val[i*DW +: DW]),
      .clear   (clear),
      .q       (q[i*DW +: DW]),
      .at_max  (at_max[i]),
`ifdef CASCADE_COUNTER_UPDOWN_EN
      .at_zero (at_zero[i])
`else
      .at_zero ()
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrapped <= 1'b0;
    end else if (clear) begin
      wrapped <= 1'b0;
    end else if (rco) begin
      wrapped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cascade_counter.sv
// tb_cascade_counter -- self-checking bench for cascade_counter.
// DUT A: NUM_DIGITS=2, MODULUS=10 (BCD-like). DUT B: NUM_DIGITS=3, MODULUS=6.
module tb_cascade_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A
  logic       rst, en, clear, load;
  logic [7:0] load_val, q;
  logic       tc, rco, wrapped;
`ifdef CASCADE_COUNTER_UPDOWN_EN
  logic       dir;
`endif

  // DUT B
  logic       enb, clearb, loadb;
  logic [8:0] load_valb, qb;
  logic       tcb, rcob, wrappedb;
`ifdef CASCADE_COUNTER_UPDOWN_EN
  logic       dirb;
`endif

  cascade_counter #(
    .NUM_DIGITS (2),
    .MODULUS    (10)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
`ifdef CASCADE_COUNTER_UPDOWN_EN
    .dir      (dir),
`endif
    .q        (q),
    .tc       (tc),
    .rco      (rco),
    .wrapped  (wrapped)
  );

  cascade_counter #(
    .NUM_DIGITS (3),
    .MODULUS    (6)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (enb),
    .clear    (clearb),
    .load     (loadb),
    .load_val (load_valb),
`ifdef CASCADE_COUNTER_UPDOWN_EN
    .dir      (dirb),
`endif
    .q        (qb),
    .tc       (tcb),
    .rco      (rcob),
    .wrapped  (wrappedb)
  );

  typedef struct {
    logic       r, cl, ld, e;
    logic [7:0] lv;
    logic       chk;       // compare tc/rco before the edge
    logic       etc, erco;
    logic [7:0] eq;        // q after the edge
    logic       ew;        // wrapped after the edge
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       w;
    string      tag;
  } exp_t;

  vec_t tbl[22];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of DUT A: drive at negedge, check combinational outputs,
  // queue the expected registered result, compare it after the edge.
  task automatic apply(input logic r, cl, ld, e, input logic [7:0] lv,
                       input logic chk, etc, erco,
                       input logic [7:0] eq, input logic ew, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; clear = cl; load = ld; en = e; load_val = lv;
    #1;
    if (chk) begin
      check({tag, " tc"}, 64'(tc), 64'(etc));
      check({tag, " rco"}, 64'(rco), 64'(erco));
    end
    sbq.push_back('{q: eq, w: ew, tag: tag});
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    check({x.tag, " q"}, 64'(q), 64'(x.q));
    check({x.tag, " wrapped"}, 64'(wrapped), 64'(x.w));
  endtask

  initial begin
    int val;
    rst = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    enb = 1'b0; clearb = 1'b0; loadb = 1'b0; load_valb = '0;
`ifdef CASCADE_COUNTER_UPDOWN_EN
    dir = 1'b0; dirb = 1'b0;
`endif

    //          r  cl ld e  lv     chk tc rco eq     ew
    tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,8'h57, 1'b0,1'b0,1'b0, 8'h00,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0, 8'h00,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0, 8'h01,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b1,8'h57, 1'b1,1'b0,1'b0, 8'h57,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0, 8'h58,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0, 8'h58,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,8'hC3, 1'b1,1'b0,1'b0, 8'h93,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,8'h99, 1'b1,1'b0,1'b0, 8'h99,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1,1'b0, 8'h99,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b1,8'h42, 1'b1,1'b1,1'b0, 8'h42,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0,8'h99, 1'b1,1'b0,1'b0, 8'h99,1'b0};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b1,8'h00, 1'b1,1'b1,1'b0, 8'h00,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b1,1'b0,8'h99, 1'b1,1'b0,1'b0, 8'h99,1'b0};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b1,1'b1, 8'h00,1'b1};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0, 8'h01,1'b1};
    tbl[15] = '{1'b1,1'b0,1'b1,1'b0,8'h42, 1'b1,1'b0,1'b0, 8'h42,1'b1};
    tbl[16] = '{1'b0,1'b0,1'b1,1'b1,8'h77, 1'b1,1'b0,1'b0, 8'h00,1'b0};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0, 8'h00,1'b0};
    tbl[18] = '{1'b1,1'b0,1'b1,1'b0,8'hFF, 1'b1,1'b0,1'b0, 8'h99,1'b0};
    tbl[19] = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b1,1'b1, 8'h00,1'b1};
    tbl[20] = '{1'b1,1'b0,1'b1,1'b0,8'h09, 1'b1,1'b0,1'b0, 8'h09,1'b1};
    tbl[21] = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0, 8'h10,1'b1};

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].r, tbl[i].cl, tbl[i].ld, tbl[i].e, tbl[i].lv,
            tbl[i].chk, tbl[i].etc, tbl[i].erco, tbl[i].eq, tbl[i].ew,
            $sformatf("row%0d", i));
    end

    // Full-range up count from zero, model kept as an integer.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "clr");
    val = 0;
    for (int k = 0; k < 99; k++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0,
            bcd(val + 1), 1'b0, $sformatf("up%0d", k));
      val = val + 1;
    end
    check("at99 q", 64'(q), 64'h99);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, "wrap99");

`ifdef CASCADE_COUNTER_UPDOWN_EN
    apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "dclr");
    dir = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 1'b1, "dwrap");
    apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, "dload");
    apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h09, 1'b1, "dborrow");
    dir = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, "dirflip");
`endif

    en = 1'b0;
    // DUT B: 215 up-counts in base 6 gives digits 5,5,5.
    @(negedge clk);
    enb = 1'b1;
    repeat (215) @(posedge clk);
    @(negedge clk);
    check("b555 q", 64'(qb), 64'h16D);
    check("b555 tc", 64'(tcb), 64'd1);
    check("b555 rco", 64'(rcob), 64'd1);
    check("b555 wrapped", 64'(wrappedb), 64'd0);
    clearb = 1'b1;
    #1;
    check("bclr rco", 64'(rcob), 64'd0);
    @(posedge clk);
    #1;
    check("bclr q", 64'(qb), 64'd0);
    check("bclr wrapped", 64'(wrappedb), 64'd0);
    check("bclr rco after", 64'(rcob), 64'd0);
    clearb = 1'b0;
    enb = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cascade_counter.md
CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of cascaded digit stages (1..16).
REQ-002 The block SHALL have parameter MODULUS, default 10, meaning the count modulus of every digit (2..256).
REQ-003 The block SHALL use derived constant DW = max(1, ceil(log2(MODULUS))), meaning the digit width in bits.
REQ-004 The block SHALL have port clk, input, 1, meaning the clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning the reset: synchronous, active-low.
REQ-006 The block SHALL have port en, input, 1, meaning count enable for digit 0.
REQ-007 The block SHALL have port clear, input, 1, meaning synchronous clear to all-zero.
REQ-008 The block SHALL have port load, input, 1, meaning parallel load of load_val.
REQ-009 The block SHALL have port load_val, input, NUM_DIGITS*DW, meaning the load value; digit i occupies bits [i*DW +: DW].
REQ-010 The block SHALL have port dir, input, 1, meaning 1 = down, 0 = up (present only under REQ-027).
REQ-011 The block SHALL have port q, output, NUM_DIGITS*DW, meaning the registered count, with digit 0 the least significant.
REQ-012 The block SHALL have port tc, output, 1, meaning combinational terminal count.
REQ-013 The block SHALL have port rco, output, 1, meaning combinational ripple carry-out for chaining another instance.
REQ-014 The block SHALL have port wrapped, output, 1, meaning a registered sticky flag that is set on full-range wrap.

Function
REQ-015 Priority SHALL be, per cycle: rst, then clear, then load, then en.
REQ-016 clear=1 SHALL set q to 0 and wrapped to 0 on the next edge.
REQ-017 load=1 SHALL write each digit with min(load_val digit, MODULUS-1); values out of range SHALL clamp to MODULUS-1; wrapped SHALL be unchanged.
REQ-018 Up, en=1: digit i SHALL advance when digit i-1 advances and is MODULUS-1 (digit 0 advances whenever en=1); MODULUS-1 SHALL wrap to 0.
REQ-019 Down, en=1: digit i SHALL step when every lower digit is 0; 0 SHALL wrap to MODULUS-1.
REQ-020 en=0 with no clear or load SHALL hold q.
REQ-021 tc SHALL be 1 iff all digits = MODULUS-1 (up) or all digits = 0 (down); it SHALL be independent of en.
REQ-022 rco SHALL equal en & tc & ~clear & ~load, with zero latency.
REQ-023 wrapped SHALL be set on the edge where rco=1, and SHALL stay set until clear or rst.
REQ-024 A dir change SHALL take effect in the same cycle; there SHALL be no pipeline stage, so count latency is 1 clock.

Reset
REQ-025 With rst=0 at a rising edge, q SHALL be 0 and wrapped SHALL be 0; after reset, tc SHALL be 0 (up) and rco SHALL be 0 while en=0.
REQ-026 Reset mid-count SHALL override clear, load and en in the same cycle.

Configuration
REQ-027 Macro CASCADE_COUNTER_UPDOWN_EN:
- Defined: the dir port SHALL exist and REQ-019 SHALL apply.
- Undefined: the dir port SHALL be absent, counting SHALL be up-only, and the down logic SHALL not be synthesised.

Structure
REQ-028 Package cascade_counter_pkg SHALL hold the function computing DW, the direction encoding constants DIR_UP=0 and DIR_DOWN=1, and the parameter range limits.
REQ-029 Per-digit logic SHALL be a sub-module, mod_counter_digit; it SHALL take inputs step, dir, load, ld_val and clear, and provide outputs q, at_max and at_zero; it SHALL be instantiated NUM_DIGITS times via generate.

Verification
REQ-030 With NUM_DIGITS=2, MODULUS=10, up, en=1 from reset for 99 cycles: q SHALL be 0x99, tc=1, rco=1, and the next edge SHALL give q=0x00 and wrapped=1.
REQ-031 load_val=0x57, load=1 together with en=1: q SHALL be 0x57 (load wins), rco SHALL be 0 that cycle, and the next en cycle SHALL give 0x58.
REQ-032 load_val=0xC3 with MODULUS=10: q SHALL be 0x93 (digit clamped).
REQ-033 Under CASCADE_COUNTER_UPDOWN_EN, with dir=1, en=1 at q=0x00: tc=1 and rco=1, and the next edge SHALL give q=0x99 and wrapped=1; 0x10 SHALL step to 0x09.
REQ-034 With MODULUS=6 and NUM_DIGITS=3, counting 215 up: q digits SHALL be 5,5,5; asserting clear and en in the same cycle SHALL give q=0, wrapped=0 and rco=0.
REQ-035 rst=0 asserted at q=0x42 together with load=1: q SHALL be 0x00 on the next edge, and wrapped SHALL be cleared.
